glitch_burst_gen: RTL and testbench
===================================

Name: glitch_burst_gen

Overview:
Parametrised successor to the single-shot clock glitcher. Produces a programmable burst of glitches on the target clock after an armed trigger: N windows, each with a programmable width and gap, after a programmable delay. Each window applies one of several glitch modes. Sits between the trigger/delay path and the target_clk pin, and takes configuration from the controller.

Parameters:
DELAY_W, 32, width of the trigger-to-first-glitch delay counter (clk cycles)
WIDTH_W, 8, width of the glitch-window and gap counters
COUNT_W, 8, width of the burst glitch-count field

Ports:
clk  in  1  FPGA clock (48 MHz); sole clock
rst  in  1  synchronous, active-high reset
clean_target_clock  in  1  divided target clock, never glitched
cfg_load  in  1  latch all cfg_* fields; accepted only in IDLE
cfg_delay  in  DELAY_W  clk cycles from trigger to first window
cfg_width  in  WIDTH_W  window length in clk cycles (0 treated as 1)
cfg_gap  in  WIDTH_W  clk cycles between windows (0 means back-to-back)
cfg_count  in  COUNT_W  number of windows in the burst
cfg_mode  in  2  0=none, 1=fast (clk_o=clk), 2=drop (clk_o=0), 3=invert (clk_o=~clean)
arm  in  1  one-cycle request: IDLE->ARMED
abort  in  1  return to IDLE from any state; no done pulse
trig  in  1  trigger level, sampled only in ARMED
clk_o  out  1  target clock output
armed  out  1  high in ARMED
busy  out  1  high in DELAY, GLITCH, GAP
done  out  1  one-cycle pulse when the burst completes

Behaviour:
- Reset state: IDLE; armed=0, busy=0, done=0, window=0; clk_o=clean_target_clock. Config registers reset to delay=0, width=1, gap=0, count=0, mode=0.
- States: IDLE, ARMED, DELAY, GLITCH, GAP, DONE.
- IDLE: cfg_load latches config. arm -> ARMED next cycle.
- ARMED: trig=1 sampled at cycle T -> DELAY at T+1 with the delay counter loaded from cfg_delay and the remaining-count register loaded from cfg_count.
  - If cfg_count=0 -> DONE instead; no window is produced.
  - arm repeated while ARMED has no effect.
- DELAY: counts down. The first window is registered-high for clk cycles T+1+D through T+D+max(W,1), with D=cfg_delay and W=cfg_width.
- GLITCH: lasts max(W,1) cycles, then decrements the remaining count.
  - Remaining>0 and G>0 -> GAP for G cycles, then GLITCH.
  - Remaining>0 and G=0 -> GLITCH immediately, so windows are contiguous.
  - Remaining=0 -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- clk_o: combinational mux driven by the registered window flag and the latched mode. With window=0, or mode=0, clk_o=clean_target_clock. Only the mux is combinational; all control is registered.
- abort: wins over every other input in the same cycle. Next cycle is IDLE, window=0, and clk_o is clean. Config is retained.
- rst mid-burst: same as abort, but config also returns to its reset values.
- cfg_load outside IDLE is ignored. trig outside ARMED is ignored. Counters never wrap, because every count terminates at zero before reload.
- Max delay 2^DELAY_W-1 clk cycles. Max burst count 2^COUNT_W-1.

Decomposition:
- Shared package glitch_pkg holds the mode enum (GM_NONE, GM_FAST, GM_DROP, GM_INVERT) and the state enum.
- Sub-module glitch_clk_mux: pure output mux (window, mode, clk, clean_target_clock -> clk_o). It is kept separate so it can be hand-placed and constrained.

Test Plan:
- delay=10, width=2, count=1, mode=1, arm, trig at T -> window high at T+11..T+12, clk_o follows clk there; done at T+13; busy T+1..T+12.
- delay=0, width=3, gap=4, count=3, mode=2 -> clk_o=0 during T+1..3, T+8..10, T+15..17; clean elsewhere; done at T+18.
- width=0, gap=0, count=2, mode=3 -> two contiguous 1-cycle windows at T+D+1 and T+D+2, clk_o=~clean; done one cycle after.
- count=0, arm, trig -> no window, busy stays 0, done pulses at T+1.
- abort asserted at the 2nd window's first cycle -> next cycle IDLE, clk_o clean, no done; a new arm+trig runs the same config fully.
- trig high while IDLE, and cfg_load while busy -> ignored; later arm+trig uses the old config; rst mid-DELAY -> IDLE, config at reset values.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared types for the glitch burst generator: output modes and FSM state codes.
// State codes are plain constants so older tools and netlists see stable encodings.
package glitch_pkg;

  typedef enum logic [1:0] {
    GM_NONE   = 2'd0,
    GM_FAST   = 2'd1,
    GM_DROP   = 2'd2,
    GM_INVERT = 2'd3
  } glitch_mode_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_DELAY  = 3'd2;
  localparam logic [2:0] ST_GLITCH = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/glitch_clk_mux.sv
// Target clock output mux: clean clock unless a glitch window is open, then the mode's source.
// Purely combinational; kept as its own module so it can be placed and constrained by hand.
module glitch_clk_mux
  import glitch_pkg::*;
(
  input  logic         clk,
  input  logic         clean_target_clock,
  input  logic         window,
  input  glitch_mode_e mode,
  output logic         clk_o
);

  always_comb begin
    clk_o = clean_target_clock;
    if (window) begin
      case (mode)
        GM_FAST:   clk_o = clk;
        GM_DROP:   clk_o = 1'b0;
        GM_INVERT: clk_o = ~clean_target_clock;
        default:   clk_o = clean_target_clock;
      endcase
    end
  end

endmodule

// File: rtl/glitch_burst_gen.sv
// Armed-trigger glitch burst sequencer: delay, then N windows of programmable width and gap.
// All control is registered; only the output clock mux is combinational. abort/rst return to IDLE next cycle.
module glitch_burst_gen
  import glitch_pkg::*;
#(
  parameter int DELAY_W = 32,
  parameter int WIDTH_W = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clean_target_clock,
  input  logic               cfg_load,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [WIDTH_W-1:0] cfg_width,
  input  logic [WIDTH_W-1:0] cfg_gap,
  input  logic [COUNT_W-1:0] cfg_count,
  input  logic [1:0]         cfg_mode,
  input  logic               arm,
  input  logic               abort,
  input  logic               trig,
  output logic               clk_o,
  output logic               armed,
  output logic               busy,
  output logic               done
);

  // One down-counter serves delay, window and gap phases, so it must hold the widest of them.
  localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

  logic [DELAY_W-1:0] delay_q;
  logic [WIDTH_W-1:0] width_q;
  logic [WIDTH_W-1:0] gap_q;
  logic [COUNT_W-1:0] count_q;
  glitch_mode_e       mode_q;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic               window_q;

  logic [CNT_W-1:0]   width_m1;
  logic [CNT_W-1:0]   gap_m1;
  logic [CNT_W-1:0]   delay_m1;

  // Counter holds "cycles left after this one"; a zero width still yields a one-cycle window.
  assign width_m1 = (width_q == '0) ? '0 : CNT_W'(width_q - 1'b1);
  assign gap_m1   = CNT_W'(gap_q - 1'b1);
  assign delay_m1 = CNT_W'(delay_q - 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig) begin
          rem_d = count_q;
          if (count_q == '0) begin
            state_d = ST_DONE;
          end else if (delay_q == '0) begin
            state_d = ST_GLITCH;
            cnt_d   = width_m1;
          end else begin
            state_d = ST_DELAY;
            cnt_d   = delay_m1;
          end
        end
      end
      ST_DELAY, ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_GLITCH;
          cnt_d   = width_m1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GLITCH: begin
        if (cnt_q == '0) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == COUNT_W'(1)) begin
            state_d = ST_DONE;
          end else if (gap_q == '0) begin
            cnt_d = width_m1;
          end else begin
            state_d = ST_GAP;
            cnt_d   = gap_m1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      window_q <= 1'b0;
      delay_q  <= '0;
      width_q  <= WIDTH_W'(1);
      gap_q    <= '0;
      count_q  <= '0;
      mode_q   <= GM_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      window_q <= (state_d == ST_GLITCH);
      if (state_q == ST_IDLE && cfg_load && !abort) begin
        delay_q <= cfg_delay;
        width_q <= cfg_width;
        gap_q   <= cfg_gap;
        count_q <= cfg_count;
        mode_q  <= glitch_mode_e'(cfg_mode);
      end
    end
  end

  assign armed = (state_q == ST_ARMED);
  assign busy  = (state_q == ST_DELAY) || (state_q == ST_GLITCH) || (state_q == ST_GAP);
  assign done  = (state_q == ST_DONE);

  glitch_clk_mux u_clk_mux (
    .clk                (clk),
    .clean_target_clock (clean_target_clock),
    .window             (window_q),
    .mode               (mode_q),
    .clk_o              (clk_o)
  );

endmodule

// File: tb/tb_glitch_burst_gen.sv
// Randomised and directed bursts checked cycle-by-cycle against a schedule computed from the burst parameters.
module tb_glitch_burst_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        clean_target_clock;
  logic        cfg_load;
  logic [31:0] cfg_delay;
  logic [7:0]  cfg_width;
  logic [7:0]  cfg_gap;
  logic [7:0]  cfg_count;
  logic [1:0]  cfg_mode;
  logic        arm;
  logic        abort;
  logic        trig;
  logic        clk_o;
  logic        armed;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  glitch_burst_gen dut (
    .clk                (clk),
    .rst                (rst),
    .clean_target_clock (clean_target_clock),
    .cfg_load           (cfg_load),
    .cfg_delay          (cfg_delay),
    .cfg_width          (cfg_width),
    .cfg_gap            (cfg_gap),
    .cfg_count          (cfg_count),
    .cfg_mode           (cfg_mode),
    .arm                (arm),
    .abort              (abort),
    .trig               (trig),
    .clk_o              (clk_o),
    .armed              (armed),
    .busy               (busy),
    .done               (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference copy of the configuration the DUT should currently hold.
  int m_d = 0, m_w = 1, m_g = 0, m_n = 0, m_m = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int end_cycle();
    int wp;
    wp = (m_w == 0) ? 1 : m_w;
    if (m_n == 0) return 1;
    return 1 + m_d + m_n * wp + (m_n - 1) * m_g;
  endfunction

  // {window, busy, done} for cycle k after the trigger cycle.
  function automatic logic [2:0] model(input int k);
    int wp, per, span, rel;
    logic w, b, d;
    if (m_n == 0) return {1'b0, 1'b0, (k == 1)};
    wp   = (m_w == 0) ? 1 : m_w;
    per  = wp + m_g;
    span = m_n * per - m_g;
    rel  = k - 1 - m_d;
    w = (rel >= 0) && (rel < span) && ((rel % per) < wp);
    b = (k >= 1) && (k < end_cycle());
    d = (k == end_cycle());
    return {w, b, d};
  endfunction

  function automatic logic exp_clk(input logic win);
    if (!win) return clean_target_clock;
    case (m_m)
      1:       return clk;
      2:       return 1'b0;
      3:       return ~clean_target_clock;
      default: return clean_target_clock;
    endcase
  endfunction

  task automatic tick(input string tag, input logic [2:0] e, input logic e_armed);
    @(posedge clk);
    #1;
    check_val({tag, ".armed"}, 32'(armed), 32'(e_armed));
    check_val({tag, ".busy"},  32'(busy),  32'(e[1]));
    check_val({tag, ".done"},  32'(done),  32'(e[0]));
    check_val({tag, ".clk_hi"}, 32'(clk_o), 32'(exp_clk(e[2])));
    clean_target_clock = 1'($urandom_range(0, 1));
    #1;
    check_val({tag, ".clk_cl"}, 32'(clk_o), 32'(exp_clk(e[2])));
    @(negedge clk);
    #1;
    check_val({tag, ".clk_lo"}, 32'(clk_o), 32'(exp_clk(e[2])));
  endtask

  // abort_at: -1 none, -2 random cycle within the burst, else fixed cycle index after trigger.
  task automatic run_burst(input string name, input int d, input int w, input int g, input int n,
                           input int m, input bit do_load, input int abort_at, input bit use_rst,
                           input bit junk);
    int  k, endk, ab;
    bit  stop;
    if (do_load) begin
      cfg_delay = d;
      cfg_width = w[7:0];
      cfg_gap   = g[7:0];
      cfg_count = n[7:0];
      cfg_mode  = m[1:0];
      cfg_load  = 1'b1;
      tick({name, ".load"}, 3'b000, 1'b0);
      cfg_load  = 1'b0;
      m_d = d; m_w = w; m_g = g; m_n = n; m_m = m;
    end
    arm = 1'b1;
    tick({name, ".arm"}, 3'b000, 1'b1);
    repeat ($urandom_range(0, 2)) begin
      arm = 1'($urandom_range(0, 1));
      tick({name, ".wait"}, 3'b000, 1'b1);
    end
    arm  = 1'b0;
    endk = end_cycle();
    ab   = (abort_at == -2) ? int'($urandom_range(1, endk)) : abort_at;
    trig = 1'b1;
    k    = 1;
    stop = 1'b0;
    while (!stop && k <= endk + 1) begin
      tick($sformatf("%s.c%0d", name, k), model(k), 1'b0);
      trig = 1'($urandom_range(0, 1));
      if (k == 1 && junk) begin
        cfg_load  = 1'b1;
        cfg_delay = $urandom_range(0, 50);
        cfg_width = 8'($urandom_range(0, 9));
        cfg_gap   = 8'($urandom_range(0, 9));
        cfg_count = 8'($urandom_range(0, 9));
        cfg_mode  = 2'($urandom_range(0, 3));
      end
      if (k == 2) cfg_load = 1'b0;
      if (k == ab) begin
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
        tick($sformatf("%s.stop%0d", name, k), 3'b000, 1'b0);
        rst      = 1'b0;
        abort    = 1'b0;
        cfg_load = 1'b0;
        if (use_rst) begin
          m_d = 0; m_w = 1; m_g = 0; m_n = 0; m_m = 0;
        end
        stop = 1'b1;
      end
      k++;
    end
    trig     = 1'b0;
    cfg_load = 1'b0;
    tick({name, ".idle"}, 3'b000, 1'b0);
  endtask

  initial begin
    rst = 1'b1; clean_target_clock = 1'b0; cfg_load = 1'b0; cfg_delay = '0;
    cfg_width = '0; cfg_gap = '0; cfg_count = '0; cfg_mode = '0;
    arm = 1'b0; abort = 1'b0; trig = 1'b0;
    tick("reset0", 3'b000, 1'b0);
    tick("reset1", 3'b000, 1'b0);
    rst = 1'b0;
    tick("post_reset", 3'b000, 1'b0);

    run_burst("fast1",   10, 2, 0, 1, 1, 1'b1, -1, 1'b0, 1'b0);
    run_burst("drop3",    0, 3, 4, 3, 2, 1'b1, -1, 1'b0, 1'b0);
    run_burst("inv_b2b",  5, 0, 0, 2, 3, 1'b1, -1, 1'b0, 1'b0);
    run_burst("count0",   4, 2, 1, 0, 1, 1'b1, -1, 1'b0, 1'b0);
    // abort on the first cycle of the second window: 1 + delay + (width + gap)
    run_burst("abort_w2", 3, 2, 2, 3, 2, 1'b1,  8, 1'b0, 1'b0);
    run_burst("rerun",    0, 0, 0, 0, 0, 1'b0, -1, 1'b0, 1'b0);

    trig = 1'b1;
    tick("idle_trig0", 3'b000, 1'b0);
    tick("idle_trig1", 3'b000, 1'b0);
    trig = 1'b0;
    run_burst("junk_load", 0, 0, 0, 0, 0, 1'b0, -1, 1'b0, 1'b1);
    run_burst("old_cfg",   0, 0, 0, 0, 0, 1'b0, -1, 1'b0, 1'b0);

    run_burst("rst_delay", 20, 2, 0, 2, 1, 1'b1, 5, 1'b1, 1'b0);
    run_burst("rst_cfg",    0, 0, 0, 0, 0, 1'b0, -1, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_burst($sformatf("rnd%0d", i),
                int'($urandom_range(0, 12)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 3)), 1'b1,
                ($urandom_range(0, 3) == 0) ? -2 : -1, 1'b0,
                1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
